led_pwm_ctrl: RTL and testbench

- Multi-channel LED driver and the parametrised successor of the fixed two-LED blinker.
- Each of NUM_LED channels is individually configured over a simple write port to OFF, ON, BLINK (free-running counter tap) or PWM (fixed duty).
- Sits next to the board GPIO pins and is driven by the SoC config logic or by tie-offs from switches.

---
 rtl/led_pwm_ctrl.sv | 170 +++++++++++++++++
 tb/tb_led_pwm_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pwm_ctrl.sv
// led_pwm_ctrl: multi-channel LED driver.
//
// Each of NUM_LED channels is configured through a one-write-per-cycle port.
// The modes are OFF, ON, BLINK (a tap of a free-running counter) and
// PWM (fixed duty against a shared prescaled PWM counter).
//
// Optional build macro LED_BREATHE_EN: a PWM-mode channel whose duty is 0
// "breathes" by ramping an internal level up and down once per PWM period
// step. Without the macro, duty 0 in PWM mode is a constant 0.
//
// Ports:
//   clk       system clock
//   rst       asynchronous active-high reset
//   cfg_we    config write strobe
//   cfg_sel   target channel (writes to cfg_sel >= NUM_LED are dropped)
//   cfg_mode  0=OFF 1=ON 2=BLINK 3=PWM
//   cfg_rate  blink counter tap index / breathe step period
//   cfg_duty  PWM duty, staged in a shadow register
//   led       registered LED drive, bit i = channel i
//   pwm_sync  one-cycle pulse in the first cycle of each PWM period
module led_pwm_ctrl #(
  parameter int NUM_LED   = 4,
  parameter int SEL_W     = 2,
  parameter int CNT_W     = 32,
  parameter int PWM_W     = 8,
  parameter int PRESC_DIV = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [SEL_W-1:0]   cfg_sel,
  input  logic [1:0]         cfg_mode,
  input  logic [4:0]         cfg_rate,
  input  logic [PWM_W-1:0]   cfg_duty,
  output logic [NUM_LED-1:0] led,
  output logic               pwm_sync
);

  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_ON    = 2'd1;
  localparam logic [1:0] MODE_BLINK = 2'd2;
  localparam logic [1:0] MODE_PWM   = 2'd3;

  localparam int PRESC_W = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;

  logic [CNT_W-1:0]   cnt;
  logic [PRESC_W-1:0] presc;
  logic [PWM_W-1:0]   pwm_cnt;
  logic               presc_last;
  logic               pwm_wrap;
  logic               sel_ok;
  logic [NUM_LED-1:0] led_next;

  assign presc_last = (presc == PRESC_W'(PRESC_DIV - 1));
  // Edge on which pwm_cnt rolls over to 0: the period boundary.
  assign pwm_wrap   = presc_last && (pwm_cnt == '1);
  assign sel_ok     = (32'(cfg_sel) < 32'(NUM_LED));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      presc    <= '0;
      pwm_cnt  <= '0;
      pwm_sync <= 1'b0;
      led      <= '0;
    end else begin
      cnt      <= cnt + 1'b1;
      presc    <= presc_last ? '0 : presc + 1'b1;
      if (presc_last) begin
        pwm_cnt <= pwm_cnt + 1'b1;
      end
      pwm_sync <= pwm_wrap;
      led      <= led_next;
    end
  end

  for (genvar g = 0; g < NUM_LED; g++) begin : g_ch
    logic [1:0]       mode;
    logic [4:0]       rate;
    logic [PWM_W-1:0] duty;
    logic [PWM_W-1:0] duty_shadow;
    logic [PWM_W-1:0] pwm_ref;
    logic [4:0]       tap;
    logic             wr;
    logic             blink;
    logic             bit_next;

    assign wr = cfg_we && sel_ok && (32'(cfg_sel) == 32'(g));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        mode        <= MODE_OFF;
        rate        <= '0;
        duty        <= '0;
        duty_shadow <= '0;
      end else begin
        if (wr) begin
          mode        <= cfg_mode;
          rate        <= cfg_rate;
          duty_shadow <= cfg_duty;
        end
        // A channel not currently in PWM has no period to protect, so the
        // new duty goes live at once. Otherwise the shadow is copied only
        // at the boundary; a write on that same edge lands in the shadow
        // while the previous shadow value becomes active.
        if (wr && (mode != MODE_PWM)) begin
          duty <= cfg_duty;
        end else if (pwm_wrap) begin
          duty <= duty_shadow;
        end
      end
    end

    // Out-of-range taps saturate to the counter MSB.
    assign tap   = (32'(rate) >= 32'(CNT_W)) ? 5'(CNT_W - 1) : rate;
    assign blink = |(cnt & ({{(CNT_W-1){1'b0}}, 1'b1} << tap));

`ifdef LED_BREATHE_EN
    logic [PWM_W-1:0] level;
    logic             dir;    // 0 = ramping up, 1 = ramping down
    logic [4:0]       step;

    // Breathe state advances on the same edge that raises pwm_sync, so a
    // new level starts exactly with the new period.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        level <= '0;
        dir   <= 1'b0;
        step  <= '0;
      end else if ((mode != MODE_PWM) || (wr && (cfg_duty != '0))) begin
        level <= '0;
        dir   <= 1'b0;
        step  <= '0;
      end else if (pwm_wrap && (duty == '0)) begin
        if (step >= rate) begin
          step <= '0;
          // Reaching an endpoint only flips direction, holding it one step.
          if (!dir) begin
            if (level == '1) dir <= 1'b1;
            else             level <= level + 1'b1;
          end else begin
            if (level == '0) dir <= 1'b0;
            else             level <= level - 1'b1;
          end
        end else begin
          step <= step + 1'b1;
        end
      end
    end

    assign pwm_ref = (duty == '0) ? level : duty;
`else
    assign pwm_ref = duty;
`endif

    always_comb begin
      bit_next = 1'b0;
      case (mode)
        MODE_OFF:   bit_next = 1'b0;
        MODE_ON:    bit_next = 1'b1;
        MODE_BLINK: bit_next = blink;
        MODE_PWM:   bit_next = (pwm_cnt < pwm_ref);
        default:    bit_next = 1'b0;
      endcase
    end

    assign led_next[g] = bit_next;
  end

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// Testbench for led_pwm_ctrl. Main instance: NUM_LED=3, CNT_W=8, PWM_W=4,
// PRESC_DIV=4 (PWM period 64 clk). A second default-parameter instance
// checks the reset-to-first-pwm_sync distance (256*64 clk).
module tb_led_pwm_ctrl;

  localparam logic [1:0] M_OFF   = 2'd0;
  localparam logic [1:0] M_ON    = 2'd1;
  localparam logic [1:0] M_BLINK = 2'd2;
  localparam logic [1:0] M_PWM   = 2'd3;

  logic       clk;
  logic       rst;
  logic       m_cfg_we;
  logic [1:0] m_cfg_sel;
  logic [1:0] m_cfg_mode;
  logic [4:0] m_cfg_rate;
  logic [3:0] m_cfg_duty;
  logic [2:0] m_led;
  logic       m_sync;

  logic       d_cfg_we;
  logic [1:0] d_cfg_sel;
  logic [1:0] d_cfg_mode;
  logic [4:0] d_cfg_rate;
  logic [7:0] d_cfg_duty;
  logic [3:0] d_led;
  logic       d_sync;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] obs;
  logic [31:0] exp;

  led_pwm_ctrl #(
    .NUM_LED(3), .SEL_W(2), .CNT_W(8), .PWM_W(4), .PRESC_DIV(4)
  ) u_dut (
    .clk(clk), .rst(rst), .cfg_we(m_cfg_we), .cfg_sel(m_cfg_sel),
    .cfg_mode(m_cfg_mode), .cfg_rate(m_cfg_rate), .cfg_duty(m_cfg_duty),
    .led(m_led), .pwm_sync(m_sync)
  );

  led_pwm_ctrl u_def (
    .clk(clk), .rst(rst), .cfg_we(d_cfg_we), .cfg_sel(d_cfg_sel),
    .cfg_mode(d_cfg_mode), .cfg_rate(d_cfg_rate), .cfg_duty(d_cfg_duty),
    .led(d_led), .pwm_sync(d_sync)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic write_cfg(input logic [1:0] sel, input logic [1:0] mode,
                           input logic [4:0] rate, input logic [3:0] duty);
    m_cfg_we   = 1'b1;
    m_cfg_sel  = sel;
    m_cfg_mode = mode;
    m_cfg_rate = rate;
    m_cfg_duty = duty;
    cyc();
    m_cfg_we   = 1'b0;
  endtask

  task automatic wait_sync(output bit ok);
    int n;
    n = 0;
    while (m_sync !== 1'b1 && n < 200) begin
      cyc();
      n++;
    end
    ok = (m_sync === 1'b1);
  endtask

  // Starts on a pwm_sync cycle, counts led[ch] highs over one 64-clk period,
  // optionally writes ch as PWM with wr_duty so it is captured on the edge
  // that ends window cycle wr_at; ends on the next pwm_sync cycle.
  task automatic measure_period(input int ch, input int wr_at,
                                input logic [3:0] wr_duty,
                                output int highs, output bit sync_ok);
    highs   = 0;
    sync_ok = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (m_led[ch] === 1'b1) highs++;
      if (i > 0 && m_sync !== 1'b0) sync_ok = 1'b0;
      if (i == wr_at) begin
        m_cfg_we   = 1'b1;
        m_cfg_sel  = 2'(ch);
        m_cfg_mode = M_PWM;
        m_cfg_rate = 5'd0;
        m_cfg_duty = wr_duty;
      end
      cyc();
      m_cfg_we = 1'b0;
    end
    if (m_sync !== 1'b1) sync_ok = 1'b0;
  endtask

  // Skips the first two led[2] edges (the first may be a mode-switch
  // artefact) and returns the clk count between the second and third.
  task automatic measure_toggle(output int gap);
    logic prev;
    int n;
    prev = m_led[2];
    for (int c = 0; c < 2; c++) begin
      n = 0;
      while (m_led[2] === prev && n < 400) begin
        cyc();
        n++;
      end
      prev = m_led[2];
    end
    n = 0;
    while (m_led[2] === prev && n < 400) begin
      cyc();
      n++;
    end
    gap = n;
  endtask

  function automatic int tri_level(input int k);
    int p;
    p = k % 32;
    return (p <= 15) ? p : 31 - p;
  endfunction

  task automatic test_reset();
    int n;
    int first_m;
    bit bad_led;
    rst = 1'b1;
    m_cfg_we = 1'b0; m_cfg_sel = '0; m_cfg_mode = '0; m_cfg_rate = '0; m_cfg_duty = '0;
    d_cfg_we = 1'b0; d_cfg_sel = '0; d_cfg_mode = '0; d_cfg_rate = '0; d_cfg_duty = '0;
    repeat (3) cyc();
    rst = 1'b0;
    repeat (20) cyc();
    write_cfg(2'd0, M_ON, 5'd0, 4'd0);
    exp_q.push_back(32'd1);
    cyc();
    obs = 32'(m_led[0]); exp = exp_q.pop_front(); n_tests++;
    if (obs !== exp) begin n_fail++; $display("FAIL pre_reset_on: got %0d want %0d", obs, exp); end

    // Reset asserted between clock edges must clear outputs at once.
    rst = 1'b1;
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd0);
    #1;
    obs = {29'd0, m_led}; exp = exp_q.pop_front(); n_tests++;
    if (obs !== exp) begin n_fail++; $display("FAIL async_rst_led: got %0h want %0h", obs, exp); end
    obs = {27'd0, d_led, d_sync}; exp = exp_q.pop_front(); n_tests++;
    if (obs !== exp) begin n_fail++; $display("FAIL async_rst_def: got %0h want %0h", obs, exp); end
    repeat (3) cyc();
    exp_q.push_back(32'd0);
    obs = {28'd0, m_led, m_sync}; exp = exp_q.pop_front(); n_tests++;
    if (obs !== exp) begin n_fail++; $display("FAIL held_rst: got %0h want %0h", obs, exp); end
    rst = 1'b0;

    exp_q.push_back(32'd0);
    exp_q.push_back(32'd64);
    exp_q.push_back(32'd16384);
    n = 0; first_m = -1; bad_led = 1'b0;
    while (n < 20000) begin
      cyc();
      n++;
      if (n <= 10 && m_led !== 3'b000) bad_led = 1'b1;
      if (m_sync === 1'b1 && first_m < 0) first_m = n;
      if (d_sync === 1'b1) break;
    end
    obs = 32'(bad_led); exp = exp_q.pop_front(); n_tests++;
    if (obs !== exp) begin n_fail++; $display("FAIL no_retain: got %0d want %0d", obs, exp); end
    obs = 32'(first_m); exp = exp_q.pop_front(); n_tests++;
    if (obs !== exp) begin n_fail++; $display("FAIL first_sync_small: got %0d want %0d", obs, exp); end
    obs = 32'(n); exp = exp_q.pop_front(); n_tests++;
    if (obs !== exp) begin n_fail++; $display("FAIL first_sync_default: got %0d want %0d", obs, exp); end
  endtask

  task automatic test_basic_modes();
    int gap;
    write_cfg(2'd0, M_ON, 5'd0, 4'd0);
    exp_q.push_back(32'd0);
    obs = 32'(m_led[0]); exp = exp_q.pop_front(); n_tests++;
    if (obs !== exp) begin n_fail++; $display("FAIL on_latency: got %0d want %0d", obs, exp); end
    write_cfg(2'd1, M_OFF, 5'd0, 4'd0);
    exp_q.push_back(32'd1);
    obs = 32'(m_led[0]); exp = exp_q.pop_front(); n_tests++;
    if (obs !== exp) begin n_fail++; $display("FAIL on_next_edge: got %0d want %0d", obs, exp); end
    write_cfg(2'd2, M_BLINK, 5'd3, 4'd0);
    cyc();
    exp_q.push_back(32'd0);
    obs = 32'(m_led[1]); exp = exp_q.pop_front(); n_tests++;
    if (obs !== exp) begin n_fail++; $display("FAIL off_mode: got %0d want %0d", obs, exp); end

    exp_q.push_back(32'd8);
    measure_toggle(gap);
    obs = 32'(gap); exp = exp_q.pop_front(); n_tests++;
    if (obs !== exp) begin n_fail++; $display("FAIL blink_rate3: got %0d want %0d", obs, exp); end

    write_cfg(2'd2, M_BLINK, 5'd0, 4'd0);
    exp_q.push_back(32'd1);
    measure_toggle(gap);
    obs = 32'(gap); exp = exp_q.pop_front(); n_tests++;
    if (obs !== exp) begin n_fail++; $display("FAIL blink_rate0: got %0d want %0d", obs, exp); end

    // CNT_W=8: rate 20 saturates to tap 7.
    write_cfg(2'd2, M_BLINK, 5'd20, 4'd0);
    exp_q.push_back(32'd128);
    measure_toggle(gap);
    obs = 32'(gap); exp = exp_q.pop_front(); n_tests++;
    if (obs !== exp) begin n_fail++; $display("FAIL blink_saturate: got %0d want %0d", obs, exp); end
  endtask

  task automatic test_pwm_duty();
    bit ok;
    int h;
    bit s;
    write_cfg(2'd2, M_PWM, 5'd0, 4'd5);
    wait_sync(ok);
    exp_q.push_back(32'd1);
    obs = 32'(ok); exp = exp_q.pop_front(); n_tests++;
    if (obs !== exp) begin n_fail++; $display("FAIL pwm_sync_seen: got %0d want %0d", obs, exp); end
    for (int p = 0; p < 2; p++) begin
      exp_q.push_back(32'd20);
      exp_q.push_back(32'd1);
      measure_period(2, -1, 4'd0, h, s);
      obs = 32'(h); exp = exp_q.pop_front(); n_tests++;
      if (obs !== exp) begin n_fail++; $display("FAIL pwm_duty5_p%0d: got %0d want %0d", p, obs, exp); end
      obs = 32'(s); exp = exp_q.pop_front(); n_tests++;
      if (obs !== exp) begin n_fail++; $display("FAIL pwm_period64_p%0d: got %0d want %0d", p, obs, exp); end
    end
  endtask

  task automatic test_duty_shadow();
    int h;
    bit s;
    int wr_at[4]      = '{10, 63, -1, -1};
    logic [3:0] wd[4] = '{4'd12, 4'd3, 4'd0, 4'd0};
    // Mid-period write waits for the boundary; a write on the boundary edge
    // itself defers one more period.
    int want[4]       = '{20, 48, 48, 12};
    for (int p = 0; p < 4; p++) begin
      exp_q.push_back(32'(want[p]));
      exp_q.push_back(32'd1);
      measure_period(2, wr_at[p], wd[p], h, s);
      obs = 32'(h); exp = exp_q.pop_front(); n_tests++;
      if (obs !== exp) begin n_fail++; $display("FAIL shadow_p%0d: got %0d want %0d", p, obs, exp); end
      obs = 32'(s); exp = exp_q.pop_front(); n_tests++;
      if (obs !== exp) begin n_fail++; $display("FAIL shadow_sync_p%0d: got %0d want %0d", p, obs, exp); end
    end
  endtask

  task automatic test_illegal_sel();
    bit ok;
    int h;
    bit s;
    write_cfg(2'd3, M_OFF, 5'd0, 4'd15);
    write_cfg(2'd3, M_ON, 5'd0, 4'd0);
    repeat (2) cyc();
    exp_q.push_back(32'd1);
    obs = {30'd0, m_led[1:0]}; exp = exp_q.pop_front(); n_tests++;
    if (obs !== exp) begin n_fail++; $display("FAIL illegal_sel_led: got %0h want %0h", obs, exp); end
    wait_sync(ok);
    exp_q.push_back(32'd12);
    measure_period(2, -1, 4'd0, h, s);
    obs = ok ? 32'(h) : 32'hFFFF_FFFF; exp = exp_q.pop_front(); n_tests++;
    if (obs !== exp) begin n_fail++; $display("FAIL illegal_sel_duty: got %0d want %0d", obs, exp); end
  endtask

  task automatic test_breathe();
    bit ok;
    int h;
    bit s;
    wait_sync(ok);
    write_cfg(2'd0, M_PWM, 5'd0, 4'd0);
    wait_sync(ok);
    for (int k = 1; k <= 34; k++) begin
`ifdef LED_BREATHE_EN
      exp_q.push_back(32'(4 * tri_level(k)));
`else
      exp_q.push_back(32'd0);
`endif
      measure_period(0, -1, 4'd0, h, s);
      obs = ok ? 32'(h) : 32'hFFFF_FFFF; exp = exp_q.pop_front(); n_tests++;
      if (obs !== exp) begin n_fail++; $display("FAIL breathe_k%0d: got %0d want %0d", k, obs, exp); end
    end

    // Nonzero duty leaves breathe; going back to duty 0 restarts from level 0.
    write_cfg(2'd0, M_PWM, 5'd0, 4'd9);
    wait_sync(ok);
    exp_q.push_back(32'd36);
    measure_period(0, -1, 4'd0, h, s);
    obs = ok ? 32'(h) : 32'hFFFF_FFFF; exp = exp_q.pop_front(); n_tests++;
    if (obs !== exp) begin n_fail++; $display("FAIL breathe_exit: got %0d want %0d", obs, exp); end
    write_cfg(2'd0, M_PWM, 5'd0, 4'd0);
    wait_sync(ok);
    exp_q.push_back(32'd0);
    measure_period(0, -1, 4'd0, h, s);
    obs = ok ? 32'(h) : 32'hFFFF_FFFF; exp = exp_q.pop_front(); n_tests++;
    if (obs !== exp) begin n_fail++; $display("FAIL breathe_restart0: got %0d want %0d", obs, exp); end
`ifdef LED_BREATHE_EN
    exp_q.push_back(32'd4);
`else
    exp_q.push_back(32'd0);
`endif
    measure_period(0, -1, 4'd0, h, s);
    obs = 32'(h); exp = exp_q.pop_front(); n_tests++;
    if (obs !== exp) begin n_fail++; $display("FAIL breathe_restart1: got %0d want %0d", obs, exp); end
  endtask

  initial begin
    test_reset();
    test_basic_modes();
    test_pwm_duty();
    test_duty_shadow();
    test_illegal_sel();
    test_breathe();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
